// File: rtl/rf_pkg.sv
// rf_pkg: shared types and defaults for the multi-port register file.
//   rf_state_e : clear/run state of the post-reset clear sequencer
//   RF_*       : default geometry and stack-pointer index
//   rf_addr_w  : address width for a given register count (min 1 bit)
package rf_pkg;

   typedef enum logic {
      RF_CLEAR,
      RF_RUN
   } rf_state_e;

   localparam int RF_DATA_W  = 16;
   localparam int RF_DEPTH   = 16;
   localparam int RF_SP_ADDR = 14;

   function automatic int rf_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rf_init_seq.sv
// rf_init_seq: post-reset clear sequencer for rf_bank.
// After rst_n rises, walks every register index once (one per cycle),
// supplying SP_RESET for the stack-pointer index and CLR_VAL elsewhere,
// then settles in RUN until the next reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   busy       : high while the clear walk is in progress
//   clr_we     : clear write strobe (equals busy)
//   clr_addr   : register index being cleared this cycle
//   clr_data   : value written to clr_addr
module rf_init_seq
   import rf_pkg::*;
#(
   parameter int                DATA_W   = RF_DATA_W,
   parameter int                DEPTH    = RF_DEPTH,
   parameter int                SP_ADDR  = RF_SP_ADDR,
   parameter logic [DATA_W-1:0] SP_RESET = '0,
   parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic                          busy,
   output logic                          clr_we,
   output logic [rf_addr_w(DEPTH)-1:0]   clr_addr,
   output logic [DATA_W-1:0]             clr_data
);

   localparam int                ADDR_W = rf_addr_w(DEPTH);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

   rf_state_e         state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      clr_we    = 1'b0;
      clr_addr  = cnt;
      clr_data  = CLR_VAL;
      case (state)
         RF_CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            if (int'(cnt) == SP_ADDR) begin
               clr_data = SP_RESET;
            end
            if (cnt == LAST) begin
               state_nxt = RF_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RF_RUN: begin
            state_nxt = RF_RUN;
         end
         default: begin
            state_nxt = RF_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/rf_bank.sv
// rf_bank: parametrised multi-port register file.
// NUM_RD registered read ports, NUM_WR write ports (higher port index wins
// on a same-address collision), optional same-cycle write-to-read bypass,
// optional hardwired zero register, and a post-reset clear walk that gives
// every register a defined value without resetting the array itself.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raddr/rdata : packed read addresses / registered read data (port 0 in LSBs)
//   we/waddr/wdata : per-port write enable, packed write address and data
//   busy        : clear walk in progress; user reads/writes not serviced
//   wr_conflict : one-cycle pulse when two enabled writes hit one address
module rf_bank
   import rf_pkg::*;
#(
   parameter int                DATA_W   = RF_DATA_W,
   parameter int                DEPTH    = RF_DEPTH,
   parameter int                NUM_RD   = 2,
   parameter int                NUM_WR   = 2,
   parameter int                BYPASS   = 1,
   parameter int                ZERO_REG = 1,
   parameter int                SP_ADDR  = RF_SP_ADDR,
   parameter logic [DATA_W-1:0] SP_RESET = '0,
   parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_RD*rf_addr_w(DEPTH)-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]             rdata,
   input  logic [NUM_WR-1:0]                    we,
   input  logic [NUM_WR*rf_addr_w(DEPTH)-1:0]   waddr,
   input  logic [NUM_WR*DATA_W-1:0]             wdata,
   output logic                                 busy,
   output logic                                 wr_conflict
);

   localparam int ADDR_W = rf_addr_w(DEPTH);

   logic [DATA_W-1:0]        mem [DEPTH];

   logic                     clr_we;
   logic [ADDR_W-1:0]        clr_addr;
   logic [DATA_W-1:0]        clr_data;

   logic [NUM_WR-1:0]        wr_en;
   logic [ADDR_W-1:0]        wa [NUM_WR];
   logic [DATA_W-1:0]        wd [NUM_WR];
   logic                     conflict_nxt;
   logic [NUM_RD*DATA_W-1:0] rdata_nxt;
   logic [ADDR_W-1:0]        ra;
   logic [DATA_W-1:0]        rval;

   rf_init_seq #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .SP_ADDR  (SP_ADDR),
      .SP_RESET (SP_RESET),
      .CLR_VAL  (CLR_VAL)
   ) u_init_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_data (clr_data)
   );

   // An address is serviceable when it exists and is not the hardwired zero.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Effective write enables: dropped while clearing, out of range, or to R0.
   always_comb begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         wa[p]    = waddr[p*ADDR_W +: ADDR_W];
         wd[p]    = wdata[p*DATA_W +: DATA_W];
         wr_en[p] = we[p] && !busy && addr_ok(wa[p]);
      end
   end

   always_comb begin
      conflict_nxt = 1'b0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         for (int unsigned q = p + 1; q < NUM_WR; q++) begin
            if (wr_en[p] && wr_en[q] && (wa[p] == wa[q])) begin
               conflict_nxt = 1'b1;
            end
         end
      end
   end

   // Bypass scans ports in ascending order so the highest port's data wins,
   // matching the array write priority below.
   always_comb begin
      rdata_nxt = '0;
      ra        = '0;
      rval      = '0;
      if (!busy) begin
         for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra   = raddr[i*ADDR_W +: ADDR_W];
            rval = '0;
            if (addr_ok(ra)) begin
               rval = mem[ra];
               if (BYPASS != 0) begin
                  for (int unsigned p = 0; p < NUM_WR; p++) begin
                     if (wr_en[p] && (wa[p] == ra)) begin
                        rval = wd[p];
                     end
                  end
               end
            end
            rdata_nxt[i*DATA_W +: DATA_W] = rval;
         end
      end
   end

   // Clear writes and user writes never coincide (wr_en is gated by busy);
   // the last non-blocking assignment gives the highest port priority.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= clr_data;
      end
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (wr_en[p]) begin
            mem[wa[p]] <= wd[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata       <= '0;
         wr_conflict <= 1'b0;
      end else begin
         rdata       <= rdata_nxt;
         wr_conflict <= conflict_nxt;
      end
   end

endmodule

// File: tb/tb_rf_bank.sv
// tb_rf_bank: directed, table-driven bench for rf_bank.
// Instance A: default parameters (BYPASS=1, DEPTH=16).
// Instance B: BYPASS=0, DEPTH=12, SP_ADDR=10, non-zero clear values.
module tb_rf_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [7:0]  a_raddr, a_waddr, b_raddr, b_waddr;
   logic [31:0] a_rdata, a_wdata, b_rdata, b_wdata;
   logic [1:0]  a_we, b_we;
   logic        a_busy, a_conf, b_busy, b_conf;

   always #5 clk = ~clk;

   rf_bank #(
      .DATA_W(16), .DEPTH(16), .NUM_RD(2), .NUM_WR(2), .BYPASS(1),
      .ZERO_REG(1), .SP_ADDR(14), .SP_RESET(16'h0000), .CLR_VAL(16'h0000)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rdata(a_rdata),
      .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
      .busy(a_busy), .wr_conflict(a_conf)
   );

   rf_bank #(
      .DATA_W(16), .DEPTH(12), .NUM_RD(2), .NUM_WR(2), .BYPASS(0),
      .ZERO_REG(1), .SP_ADDR(10), .SP_RESET(16'h5A5A), .CLR_VAL(16'h1111)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rdata(b_rdata),
      .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
      .busy(b_busy), .wr_conflict(b_conf)
   );

   typedef struct {
      logic [1:0]  we;
      logic [3:0]  wa1, wa0;
      logic [15:0] wd1, wd0;
      logic [3:0]  ra1, ra0;
      logic [15:0] exp1, exp0;
      logic        exp_conf;
   } vec_t;

   vec_t ta [12];
   vec_t tv [11];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit is_b, input vec_t v);
      if (!is_b) begin
         a_we = v.we; a_waddr = {v.wa1, v.wa0};
         a_wdata = {v.wd1, v.wd0}; a_raddr = {v.ra1, v.ra0};
      end else begin
         b_we = v.we; b_waddr = {v.wa1, v.wa0};
         b_wdata = {v.wd1, v.wd0}; b_raddr = {v.ra1, v.ra0};
      end
   endtask

   // Expected post-clear contents of instance B as seen on a read port.
   function automatic logic [15:0] b_clr(input int a);
      if (a == 0 || a >= 12) return 16'h0000;
      if (a == 10) return 16'h5A5A;
      return 16'h1111;
   endfunction

   // Counts edges after rst_n release until busy drops; issues a write to R2
   // at edge 10 (still inside both clear walks) and watches rdata while busy.
   task automatic measure_clear(output int ca, output int cb, output bit rd_zero);
      ca = -1; cb = -1; rd_zero = 1'b1;
      a_raddr = {4'd2, 4'd14};
      b_raddr = {4'd2, 4'd10};
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin
            a_we = 2'b01; a_waddr = {4'd0, 4'd2}; a_wdata = {16'h0, 16'h7777};
            b_we = 2'b01; b_waddr = {4'd0, 4'd2}; b_wdata = {16'h0, 16'h7777};
         end else begin
            a_we = 2'b00; b_we = 2'b00;
         end
         tick;
         if (ca < 0 && !a_busy) ca = k;
         if (cb < 0 && !b_busy) cb = k;
         if (a_busy && a_rdata != 32'h0) rd_zero = 1'b0;
         if (b_busy && b_rdata != 32'h0) rd_zero = 1'b0;
         if (ca >= 0 && cb >= 0) break;
      end
      a_we = 2'b00; b_we = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int  ca, cb;
      bit  rz;

      a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
      b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0;

      //          we     wa1   wa0   wd1       wd0       ra1    ra0    exp1      exp0      conf
      ta[0]  = '{2'b01, 4'd0, 4'd3, 16'h0000, 16'hBEEF, 4'd4,  4'd3,  16'h0000, 16'hBEEF, 1'b0};
      ta[1]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd3,  4'd3,  16'hBEEF, 16'hBEEF, 1'b0};
      ta[2]  = '{2'b10, 4'd5, 4'd0, 16'h1234, 16'h0000, 4'd5,  4'd3,  16'h1234, 16'hBEEF, 1'b0};
      ta[3]  = '{2'b11, 4'd7, 4'd7, 16'h5555, 16'hAAAA, 4'd7,  4'd7,  16'h5555, 16'h5555, 1'b1};
      ta[4]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd7,  4'd7,  16'h5555, 16'h5555, 1'b0};
      ta[5]  = '{2'b11, 4'd0, 4'd0, 16'h2222, 16'h1111, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b0};
      ta[6]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd5,  4'd0,  16'h1234, 16'h0000, 1'b0};
      ta[7]  = '{2'b11, 4'd10,4'd9, 16'hF0F0, 16'h0F0F, 4'd10, 4'd9,  16'hF0F0, 16'h0F0F, 1'b0};
      ta[8]  = '{2'b01, 4'd9, 4'd9, 16'h2468, 16'h1357, 4'd9,  4'd9,  16'h1357, 16'h1357, 1'b0};
      ta[9]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd10, 4'd9,  16'hF0F0, 16'h1357, 1'b0};
      ta[10] = '{2'b11, 4'd14,4'd14,16'hDCBA, 16'hABCD, 4'd14, 4'd13, 16'hDCBA, 16'h0000, 1'b1};
      ta[11] = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd14, 4'd3,  16'hDCBA, 16'hBEEF, 1'b0};

      tv[0]  = '{2'b01, 4'd0, 4'd3, 16'h0000, 16'hBEEF, 4'd10, 4'd3,  16'h5A5A, 16'h1111, 1'b0};
      tv[1]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd3,  4'd3,  16'hBEEF, 16'hBEEF, 1'b0};
      tv[2]  = '{2'b01, 4'd0, 4'd13,16'h0000, 16'hFFFF, 4'd12, 4'd13, 16'h0000, 16'h0000, 1'b0};
      tv[3]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd1,  4'd13, 16'h1111, 16'h0000, 1'b0};
      tv[4]  = '{2'b11, 4'd13,4'd13,16'hEEEE, 16'hFFFF, 4'd11, 4'd13, 16'h1111, 16'h0000, 1'b0};
      tv[5]  = '{2'b11, 4'd7, 4'd7, 16'h5555, 16'hAAAA, 4'd7,  4'd7,  16'h1111, 16'h1111, 1'b1};
      tv[6]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd7,  4'd7,  16'h5555, 16'h5555, 1'b0};
      tv[7]  = '{2'b10, 4'd5, 4'd0, 16'h1234, 16'h0000, 4'd5,  4'd0,  16'h1111, 16'h0000, 1'b0};
      tv[8]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd5,  4'd5,  16'h1234, 16'h1234, 1'b0};
      tv[9]  = '{2'b11, 4'd0, 4'd0, 16'h9999, 16'h8888, 4'd10, 4'd0,  16'h5A5A, 16'h0000, 1'b0};
      tv[10] = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd0,  4'd3,  16'h0000, 16'hBEEF, 1'b0};

      // Reset state
      tick; tick;
      check("reset A busy", 32'(a_busy), 32'd1);
      check("reset A rdata", a_rdata, 32'h0);
      check("reset A wr_conflict", 32'(a_conf), 32'd0);
      check("reset B busy", 32'(b_busy), 32'd1);
      check("reset B rdata", b_rdata, 32'h0);

      // Clear sequence
      rst_n = 1'b1;
      measure_clear(ca, cb, rz);
      check("A clear length", 32'(ca), 32'd16);
      check("B clear length", 32'(cb), 32'd12);
      check("rdata zero while busy", 32'(rz), 32'd1);

      // Post-clear contents; the write issued while busy must not show in R2
      for (int i = 0; i < 16; i++) begin
         a_raddr = {4'(15 - i), 4'(i)};
         b_raddr = {4'(15 - i), 4'(i)};
         tick;
         check($sformatf("A clear R%0d", i), 32'(a_rdata[15:0]), 32'h0);
         check($sformatf("B clear p0 R%0d", i), 32'(b_rdata[15:0]), 32'(b_clr(i)));
         check($sformatf("B clear p1 R%0d", 15 - i), 32'(b_rdata[31:16]), 32'(b_clr(15 - i)));
      end

      // Instance A vectors (bypass on)
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, ta[i]);
         tick;
         check($sformatf("A row%0d rdata0", i), 32'(a_rdata[15:0]), 32'(ta[i].exp0));
         check($sformatf("A row%0d rdata1", i), 32'(a_rdata[31:16]), 32'(ta[i].exp1));
         check($sformatf("A row%0d wr_conflict", i), 32'(a_conf), 32'(ta[i].exp_conf));
      end
      a_we = 2'b00;

      // Instance B vectors (no bypass, DEPTH=12)
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, tv[i]);
         tick;
         check($sformatf("B row%0d rdata0", i), 32'(b_rdata[15:0]), 32'(tv[i].exp0));
         check($sformatf("B row%0d rdata1", i), 32'(b_rdata[31:16]), 32'(tv[i].exp1));
         check($sformatf("B row%0d wr_conflict", i), 32'(b_conf), 32'(tv[i].exp_conf));
      end
      b_we = 2'b00;

      // Reset from RUN is asynchronous: busy and rdata respond before any edge
      rst_n = 1'b0;
      #1;
      check("async reset A busy", 32'(a_busy), 32'd1);
      check("async reset A rdata", a_rdata, 32'h0);
      tick;
      rst_n = 1'b1;

      // Reset pulse during clear cycle 6 restarts a full-length clear
      for (int k = 0; k < 6; k++) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      measure_clear(ca, cb, rz);
      check("A clear length after mid-clear reset", 32'(ca), 32'd16);
      check("B clear length after mid-clear reset", 32'(cb), 32'd12);
      check("rdata zero while busy (2nd)", 32'(rz), 32'd1);

      a_raddr = {4'd14, 4'd3};
      b_raddr = {4'd3, 4'd2};
      tick;
      check("A R3 recleared", 32'(a_rdata[15:0]), 32'h0);
      check("A R14 SP recleared", 32'(a_rdata[31:16]), 32'h0);
      check("B R2 busy write lost", 32'(b_rdata[15:0]), 32'h1111);
      check("B R3 recleared", 32'(b_rdata[31:16]), 32'h1111);
      a_raddr = {4'd2, 4'd7};
      tick;
      check("A R2 busy write lost", 32'(a_rdata[31:16]), 32'h0);
      check("A R7 recleared", 32'(a_rdata[15:0]), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
